// File: rtl/uartcon_pkg.sv
// rtl/uartcon_pkg.sv - shared constants and serializer state encoding for the UART transmitter
package uartcon_pkg;

    localparam int CLK_DIV_DEFAULT    = 434;
    localparam int DEPTH_LOG2_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uartcon_fifo.sv
// rtl/uartcon_fifo.sv - synchronous byte FIFO with registered count-based flags
module uartcon_fifo #(
    parameter int P_DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       afull,
    output logic       empty
);

    localparam int                  DEPTH     = 1 << P_DEPTH_LOG2;
    localparam logic [P_DEPTH_LOG2:0] CNT_ONE   = (P_DEPTH_LOG2 + 1)'(1);
    localparam logic [P_DEPTH_LOG2:0] FULL_LVL  = (P_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [P_DEPTH_LOG2:0] AFULL_LVL = (P_DEPTH_LOG2 + 1)'(DEPTH - 2);
    localparam logic [P_DEPTH_LOG2-1:0] PTR_ONE = P_DEPTH_LOG2'(1);

    logic [7:0]              mem [DEPTH];
    logic [P_DEPTH_LOG2-1:0] wptr;
    logic [P_DEPTH_LOG2-1:0] rptr;
    logic [P_DEPTH_LOG2:0]   cnt;
    logic [P_DEPTH_LOG2:0]   cnt_next;
    logic                    push_ok;
    logic                    pop_ok;

    // A push while full is dropped outright; pop from empty is ignored.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        cnt_next = cnt;
        if (push_ok && !pop_ok) begin
            cnt_next = cnt + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            cnt_next = cnt - CNT_ONE;
        end
    end

    // Flags come from the next count so they are valid right after the edge that moves it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            full  <= 1'b0;
            afull <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop_ok) begin
                rptr <= rptr + PTR_ONE;
            end
            cnt   <= cnt_next;
            full  <= (cnt_next == FULL_LVL);
            afull <= (cnt_next >= AFULL_LVL);
            empty <= (cnt_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/uartcon_tx.sv
// rtl/uartcon_tx.sv - buffered 8N1 UART transmitter: byte FIFO feeding a registered-line serializer
module uartcon_tx
    import uartcon_pkg::*;
#(
    parameter int P_CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int P_DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       WRITE,
    input  logic [7:0] WDATA,
    output logic       FULL,
    output logic       AFULL,
    output logic       WEMPTY,
    output logic       TXD
);

    localparam logic [15:0] TIMER_LAST = 16'(P_CLK_DIV - 1);
    localparam logic [15:0] TIMER_ONE  = 16'd1;
    localparam logic [2:0]  LAST_BIT   = 3'd7;

    tx_state_t   state;
    tx_state_t   next_state;
    logic [15:0] bit_timer;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        bit_end;
    logic        pop;
    logic        push_acc;
    logic        txd_next;
    logic        wempty_next;
    logic        fifo_empty;
    logic        fifo_full;
    logic [7:0]  fifo_rdata;

    uartcon_fifo #(
        .P_DEPTH_LOG2(P_DEPTH_LOG2)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (WRITE),
        .wdata (WDATA),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .afull (AFULL),
        .empty (fifo_empty)
    );

    assign FULL     = fifo_full;
    assign bit_end  = (bit_timer == TIMER_LAST);
    assign push_acc = WRITE && !fifo_full;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    next_state = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && (bit_cnt == LAST_BIT)) begin
                    next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    next_state = fifo_empty ? S_IDLE : S_START;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // WEMPTY only rises once a cycle has been spent idle, i.e. after the stop bit is on the line.
    always_comb begin
        pop         = 1'b0;
        txd_next    = 1'b1;
        wempty_next = (state == S_IDLE) && fifo_empty && !push_acc;
        case (state)
            S_IDLE: begin
                pop = !fifo_empty;
            end
            S_START: begin
                txd_next = 1'b0;
            end
            S_DATA: begin
                txd_next = shreg[0];
            end
            S_STOP: begin
                pop = bit_end && !fifo_empty;
            end
            default: begin
                txd_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bit_timer <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
        end else if (pop) begin
            shreg     <= fifo_rdata;
            bit_timer <= '0;
            bit_cnt   <= '0;
        end else if (state == S_IDLE) begin
            bit_timer <= '0;
        end else if (bit_end) begin
            bit_timer <= '0;
            if (state == S_DATA) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {1'b0, shreg[7:1]};
            end
        end else begin
            bit_timer <= bit_timer + TIMER_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            TXD    <= 1'b1;
            WEMPTY <= 1'b1;
        end else begin
            TXD    <= txd_next;
            WEMPTY <= wempty_next;
        end
    end

endmodule

// File: tb/tb_uartcon_tx.sv
// tb/tb_uartcon_tx.sv - self-checking bench for uartcon_tx against a frame-level reference model
module tb_uartcon_tx;

    localparam int D     = 4;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       WRITE = 1'b0;
    logic [7:0] WDATA = 8'h00;
    logic       FULL;
    logic       AFULL;
    logic       WEMPTY;
    logic       TXD;

    uartcon_tx #(
        .P_CLK_DIV    (D),
        .P_DEPTH_LOG2 (DL)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .WRITE  (WRITE),
        .WDATA  (WDATA),
        .FULL   (FULL),
        .AFULL  (AFULL),
        .WEMPTY (WEMPTY),
        .TXD    (TXD)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: stored bytes, and the frame currently occupying the line.
    byte unsigned q[$];
    byte unsigned acc_log[$];
    bit           active = 1'b0;
    int           fstart = 0;
    int           fend = 0;
    byte unsigned fbyte = 8'h00;
    bit           exp_txd = 1'b1;
    bit           exp_full = 1'b0;
    bit           exp_afull = 1'b0;
    bit           exp_wempty = 1'b1;

    // Line decoder that samples mid-bit, independent of the model.
    byte unsigned rx_q[$];
    bit           rx_busy = 1'b0;
    int           rx_t = 0;
    byte unsigned rx_b = 8'h00;

    function automatic bit frame_bit(input byte unsigned b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic step(input bit rst, input bit wr, input byte unsigned d);
        bit act_before;
        bit pop_now;
        int qs;
        RST_N = rst;
        WRITE = wr;
        WDATA = d;
        @(posedge CLK);
        cyc++;
        if (!rst) begin
            q.delete();
            active     = 1'b0;
            exp_txd    = 1'b1;
            exp_full   = 1'b0;
            exp_afull  = 1'b0;
            exp_wempty = 1'b1;
        end else begin
            act_before = active;
            exp_txd = act_before ? frame_bit(fbyte, (cyc - fstart - 1) / D) : 1'b1;
            qs = q.size();
            pop_now = (qs > 0) && (!active || cyc == fend);
            if (active && cyc == fend) active = 1'b0;
            if (pop_now) begin
                fbyte  = q.pop_front();
                fstart = cyc;
                fend   = cyc + 10 * D;
                active = 1'b1;
            end
            if (wr && qs < DEPTH) begin
                q.push_back(d);
                acc_log.push_back(d);
            end
            exp_full   = (q.size() == DEPTH);
            exp_afull  = (q.size() >= DEPTH - 2);
            exp_wempty = (q.size() == 0) && !act_before && !active;
        end
        #1;
        checks += 4;
        if (TXD !== exp_txd) begin
            errors++;
            $display("FAIL txd cyc=%0d got=%b exp=%b", cyc, TXD, exp_txd);
        end
        if (FULL !== exp_full) begin
            errors++;
            $display("FAIL full cyc=%0d got=%b exp=%b", cyc, FULL, exp_full);
        end
        if (AFULL !== exp_afull) begin
            errors++;
            $display("FAIL afull cyc=%0d got=%b exp=%b", cyc, AFULL, exp_afull);
        end
        if (WEMPTY !== exp_wempty) begin
            errors++;
            $display("FAIL wempty cyc=%0d got=%b exp=%b", cyc, WEMPTY, exp_wempty);
        end
        if (!rst) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (TXD === 1'b0) begin
                rx_busy = 1'b1;
                rx_t    = 0;
            end
        end else begin
            rx_t++;
            if (rx_t == D / 2 + 9 * D) begin
                rx_q.push_back(rx_b);
                rx_busy = 1'b0;
            end else if (rx_t >= D / 2 + D && ((rx_t - D / 2) % D) == 0) begin
                rx_b[(rx_t - D / 2) / D - 1] = TXD;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while (!(WEMPTY === 1'b1 && !active && q.size() == 0) && k < limit) begin
            step(1'b1, 1'b0, 8'h00);
            k++;
        end
        checks++;
        if (k >= limit) begin
            errors++;
            $display("FAIL drain_timeout got=%0d cycles exp=<%0d", k, limit);
        end
        idle(3);
    endtask

    task automatic check_rx(input string name, input byte unsigned exp_b[$]);
        checks++;
        if (rx_q.size() != exp_b.size()) begin
            errors++;
            $display("FAIL %s_count got=%0d exp=%0d", name, rx_q.size(), exp_b.size());
        end else begin
            foreach (exp_b[i]) begin
                checks++;
                if (rx_q[i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL %s_byte%0d got=%h exp=%h", name, i, rx_q[i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hAA);
        checks += 4;
        if (TXD !== 1'b1) begin errors++; $display("FAIL reset_txd got=%b exp=1", TXD); end
        if (FULL !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", FULL); end
        if (AFULL !== 1'b0) begin errors++; $display("FAIL reset_afull got=%b exp=0", AFULL); end
        if (WEMPTY !== 1'b1) begin errors++; $display("FAIL reset_wempty got=%b exp=1", WEMPTY); end
        idle(5);
        checks += 2;
        if (WEMPTY !== 1'b1) begin errors++; $display("FAIL reset_write_ignored_wempty got=%b exp=1", WEMPTY); end
        if (TXD !== 1'b1) begin errors++; $display("FAIL reset_write_ignored_txd got=%b exp=1", TXD); end
    endtask

    task automatic test_single_byte();
        logic       s[0:47];
        logic [9:0] pat;
        pat = 10'b1001111100;
        rx_q.delete();
        step(1'b1, 1'b1, 8'h3E);
        s[0] = TXD;
        for (int i = 1; i < 48; i++) begin
            step(1'b1, 1'b0, 8'h00);
            s[i] = TXD;
            if (i == 41) begin
                checks++;
                if (WEMPTY !== 1'b0) begin errors++; $display("FAIL single_wempty_in_stop got=%b exp=0", WEMPTY); end
            end
        end
        checks += 2;
        if (s[1] !== 1'b1) begin errors++; $display("FAIL single_pre_start got=%b exp=1", s[1]); end
        if (s[42] !== 1'b1) begin errors++; $display("FAIL single_post_stop got=%b exp=1", s[42]); end
        for (int j = 0; j < 10; j++) begin
            checks++;
            if (s[2 + 4 * j + 2] !== pat[j]) begin
                errors++;
                $display("FAIL single_bit%0d got=%b exp=%b", j, s[2 + 4 * j + 2], pat[j]);
            end
        end
        checks++;
        if (WEMPTY !== 1'b1) begin errors++; $display("FAIL single_wempty_after got=%b exp=1", WEMPTY); end
        check_rx("single", '{8'h3E});
    endtask

    task automatic test_back_to_back();
        logic         s[0:139];
        byte unsigned b[3];
        int           f;
        b[0] = 8'h41; b[1] = 8'h43; b[2] = 8'h4B;
        rx_q.delete();
        for (int i = 0; i < 140; i++) begin
            step(1'b1, i < 3, (i < 3) ? b[i] : 8'h00);
            s[i] = TXD;
        end
        f = -1;
        for (int i = 0; i < 140 && f < 0; i++) if (s[i] === 1'b0) f = i;
        checks++;
        if (f != 2) begin
            errors++;
            $display("FAIL b2b_first_start got=%0d exp=2", f);
        end else begin
            for (int k = 0; k < 120; k++) begin
                checks++;
                if (s[f + k] !== frame_bit(b[k / 40], (k % 40) / D)) begin
                    errors++;
                    $display("FAIL b2b_line k=%0d got=%b exp=%b", k, s[f + k], frame_bit(b[k / 40], (k % 40) / D));
                end
            end
            checks++;
            if (s[f + 120] !== 1'b1) begin errors++; $display("FAIL b2b_idle_after got=%b exp=1", s[f + 120]); end
        end
        drain(200);
        check_rx("b2b", '{8'h41, 8'h43, 8'h4B});
    endtask

    task automatic test_overflow();
        byte unsigned exp_b[$];
        rx_q.delete();
        for (int k = 0; k < 18; k++) begin
            step(1'b1, 1'b1, 8'(k));
            if (k == 13) begin checks++; if (AFULL !== 1'b0) begin errors++; $display("FAIL ovf_afull13 got=%b exp=0", AFULL); end end
            if (k == 14) begin checks++; if (AFULL !== 1'b1) begin errors++; $display("FAIL ovf_afull14 got=%b exp=1", AFULL); end end
            if (k == 15) begin checks++; if (FULL !== 1'b0) begin errors++; $display("FAIL ovf_full15 got=%b exp=0", FULL); end end
            if (k == 16) begin checks++; if (FULL !== 1'b1) begin errors++; $display("FAIL ovf_full16 got=%b exp=1", FULL); end end
            if (k == 17) begin checks++; if (FULL !== 1'b1) begin errors++; $display("FAIL ovf_full17 got=%b exp=1", FULL); end end
        end
        drain(1000);
        for (int k = 0; k < 17; k++) exp_b.push_back(8'(k));
        check_rx("ovf", exp_b);
    endtask

    task automatic test_simultaneous();
        int k;
        rx_q.delete();
        step(1'b1, 1'b1, 8'hA5);
        step(1'b1, 1'b1, 8'h5A);
        k = 0;
        while (cyc < fend - 1 && k < 100) begin
            step(1'b1, 1'b0, 8'h00);
            k++;
        end
        step(1'b1, 1'b1, 8'hC3);
        checks += 3;
        if (FULL !== 1'b0) begin errors++; $display("FAIL simul_full got=%b exp=0", FULL); end
        if (AFULL !== 1'b0) begin errors++; $display("FAIL simul_afull got=%b exp=0", AFULL); end
        if (WEMPTY !== 1'b0) begin errors++; $display("FAIL simul_wempty got=%b exp=0", WEMPTY); end
        drain(300);
        check_rx("simul", '{8'hA5, 8'h5A, 8'hC3});
    endtask

    task automatic test_reset_midframe();
        int k;
        rx_q.delete();
        step(1'b1, 1'b1, 8'h55);
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 8'(8'h60 + i));
        k = 0;
        while (cyc < fstart + 17 && k < 100) begin
            step(1'b1, 1'b0, 8'h00);
            k++;
        end
        step(1'b0, 1'b1, 8'hEE);
        checks += 4;
        if (TXD !== 1'b1) begin errors++; $display("FAIL rstmid_txd got=%b exp=1", TXD); end
        if (WEMPTY !== 1'b1) begin errors++; $display("FAIL rstmid_wempty got=%b exp=1", WEMPTY); end
        if (FULL !== 1'b0) begin errors++; $display("FAIL rstmid_full got=%b exp=0", FULL); end
        if (AFULL !== 1'b0) begin errors++; $display("FAIL rstmid_afull got=%b exp=0", AFULL); end
        idle(100);
        checks += 2;
        if (rx_q.size() != 0) begin errors++; $display("FAIL rstmid_frames got=%0d exp=0", rx_q.size()); end
        if (WEMPTY !== 1'b1) begin errors++; $display("FAIL rstmid_wempty_after got=%b exp=1", WEMPTY); end
    endtask

    task automatic test_handshake();
        byte unsigned m[5];
        int  c0;
        bit  early;
        int  k;
        m[0] = 8'h41; m[1] = 8'h43; m[2] = 8'h4B; m[3] = 8'h0D; m[4] = 8'h0A;
        rx_q.delete();
        step(1'b1, 1'b1, m[0]);
        c0 = cyc;
        early = (WEMPTY !== 1'b0);
        for (int i = 1; i < 5; i++) begin
            step(1'b1, 1'b1, m[i]);
            if (WEMPTY !== 1'b0) early = 1'b1;
        end
        while (cyc < c0 + 200) begin
            step(1'b1, 1'b0, 8'h00);
            if (WEMPTY !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin errors++; $display("FAIL hs_wempty_early got=1 exp=0 within 200 cycles"); end
        k = 0;
        while (WEMPTY !== 1'b1 && k < 10) begin
            step(1'b1, 1'b0, 8'h00);
            k++;
        end
        checks++;
        if (cyc - c0 > 203) begin
            errors++;
            $display("FAIL hs_wempty_rise got=%0d cycles exp<=203", cyc - c0);
        end
        idle(5);
        check_rx("hs", '{m[0], m[1], m[2], m[3], m[4]});
    endtask

    task automatic test_random();
        bit wr;
        rx_q.delete();
        acc_log.delete();
        for (int i = 0; i < 3000; i++) begin
            wr = ($urandom_range(0, 59) < 2) || (i >= 1500 && i < 1520);
            step(1'b1, wr, 8'($urandom_range(0, 255)));
        end
        drain(1200);
        check_rx("rand", acc_log);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_simultaneous();
        test_reset_midframe();
        test_handshake();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
